// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - decode-side bundle between the ID stage and the exception/mode sequencer
//
// Purpose: groups the event inputs (exception vector, rfe, interrupt, stall, return PC)
// and the sequencer outputs (mode, flush, PC-mux control, saved state).
// Modports:
//   master - ID stage / decode side: drives events, observes sequencer outputs
//   slave  - exc_ctrl: consumes events, drives mode/flush/PC controls
interface exc_ctrl_if;
    logic [4:0]  vector_id;
    logic        rfe_id;
    logic [31:0] epc_in;
    logic        irq;
    logic        stall;
    logic        s_u;
    logic        ie;
    logic        exc_flush;
    logic        exc_pc_sel;
    logic [31:0] exc_target;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        busy;

    modport master (
        output vector_id, rfe_id, epc_in, irq, stall,
        input  s_u, ie, exc_flush, exc_pc_sel, exc_target, epc, cause, busy
    );

    modport slave (
        input  vector_id, rfe_id, epc_in, irq, stall,
        output s_u, ie, exc_flush, exc_pc_sel, exc_target, epc, cause, busy
    );
endinterface

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/mode sequencer for the ID stage
//
// Purpose: accepts exceptions, interrupts and rfe from decode; flushes the pipeline,
// vectors the PC, saves EPC/cause/previous mode and restores them on rfe.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous, active-high
//   bus   - exc_ctrl_if.slave: event inputs and mode/flush/PC-mux outputs
module exc_ctrl #(
    parameter logic [31:0] VEC_BASE     = 32'h0000_0080,
    parameter int          VEC_SH       = 3,
    parameter logic [4:0]  IRQ_CAUSE    = 5'd31,
    parameter logic [4:0]  PRIV_CAUSE   = 5'd10,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    exc_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, VECTOR, RETURN} state_t;

    localparam logic [2:0] CNT_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic        s_u_q, s_u_d;
    logic        ie_q, ie_d;
    logic        pmode_q, pmode_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  cause_q, cause_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        take;
    logic [4:0]  take_cause;
    logic        flush;
    logic        pc_sel;
    logic [31:0] target;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_u_q   <= 1'b0;
            ie_q    <= 1'b0;
            pmode_q <= 1'b0;
            epc_q   <= 32'h0;
            cause_q <= 5'h0;
            cnt_q   <= 3'h0;
        end else begin
            state_q <= state_d;
            s_u_q   <= s_u_d;
            ie_q    <= ie_d;
            pmode_q <= pmode_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_u_d      = s_u_q;
        ie_d       = ie_q;
        pmode_d    = pmode_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        cnt_d      = cnt_q;
        take       = 1'b0;
        take_cause = 5'h0;
        flush      = 1'b0;
        pc_sel     = 1'b0;
        target     = 32'h0;

        case (state_q)
            IDLE: begin
                // Events are only looked at here; everything arriving while busy is dropped.
                if (!bus.stall) begin
                    if (bus.vector_id != 5'h0) begin
                        take       = 1'b1;
                        take_cause = bus.vector_id;
                    end else if (bus.irq && ie_q) begin
                        take       = 1'b1;
                        take_cause = IRQ_CAUSE;
                    end else if (bus.rfe_id && s_u_q) begin
                        // rfe from user mode is a privilege violation
                        take       = 1'b1;
                        take_cause = PRIV_CAUSE;
                    end else if (bus.rfe_id) begin
                        state_d = RETURN;
                    end
                end
                if (take) begin
                    cause_d = take_cause;
                    epc_d   = bus.epc_in;
                    pmode_d = s_u_q;
                    s_u_d   = 1'b0;
                    ie_d    = 1'b0;
                    cnt_d   = 3'h0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (!bus.stall) begin
                    cnt_d = cnt_q + 3'h1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = VECTOR;
                    end
                end
            end
            VECTOR: begin
                flush  = 1'b1;
                pc_sel = 1'b1;
                target = VEC_BASE + ({27'h0, cause_q} << VEC_SH);
                if (!bus.stall) begin
                    state_d = IDLE;
                end
            end
            RETURN: begin
                flush  = 1'b1;
                pc_sel = 1'b1;
                target = epc_q;
                if (!bus.stall) begin
                    s_u_d   = pmode_q;
                    ie_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_u        = s_u_q;
    assign bus.ie         = ie_q;
    assign bus.exc_flush  = flush;
    assign bus.exc_pc_sel = pc_sel;
    assign bus.exc_target = target;
    assign bus.epc        = epc_q;
    assign bus.cause      = cause_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
